gpio_bank_mmio: RTL and testbench
=================================

Name: gpio_bank_mmio

Overview:
Parametrised memory-mapped GPIO bank, generalising the single-register LED port to NUM_PINS bidirectional pins. It provides:
- per-pin direction control
- atomic set/clear/toggle of outputs
- two-flop input synchronisers
- per-pin rising/falling edge interrupt capture with write-1-to-clear status and an aggregated irq line

It sits on the CPU data bus alongside RAM and other MMIO slaves; its read data is OR-muxed onto the bus.

Parameters:
- NUM_PINS, 8: number of GPIO pins, 1..32
- BASE_MEMORY, 32'hFFFF_FF00: byte address of register 0; must be 64-byte aligned
- OUT_RESET, 32'h0000_0000: reset value of OUT register (bits >= NUM_PINS ignored)

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- memAddress  input  32  bus byte address
- memWriteData  input  32  bus write data
- memWrite  input  1  write strobe, valid for one cycle
- byteMask  input  4  byte enables; bit i enables byte [8i+7:8i]
- memReadData  output  32  registered read data
- gpioIn  input  NUM_PINS  asynchronous pin inputs
- gpioOut  output  NUM_PINS  pin output values (= OUT)
- gpioOe  output  NUM_PINS  pin output enables (= DIR, 1 = drive)
- irq  output  1  OR of (STATUS)

Behaviour:
- Select: hit = memAddress within [BASE_MEMORY, BASE_MEMORY+0x3F]. Word offset = memAddress[5:2]; memAddress[1:0] ignored.
- Register map (offset, access):
  - 0x00 OUT rw
  - 0x04 DIR rw
  - 0x08 IN ro (synchronised pins)
  - 0x0C SET wo (OUT |= data)
  - 0x10 CLR wo (OUT &= ~data)
  - 0x14 TGL wo (OUT ^= data)
  - 0x18 RISE_EN rw
  - 0x1C FALL_EN rw
  - 0x20 STATUS rw1c
  - 0x24..0x3C reserved: read 0, writes ignored
- Write-only registers read as 0.
- Writes: take effect on the clk edge where hit && memWrite. Only enabled bytes participate: for SET/CLR/TGL/STATUS, data bits in disabled bytes are treated as 0. Bits >= NUM_PINS are never stored and read 0.
- Reads: memReadData is registered, valid the cycle after the address is presented (1-cycle latency, same as RAM). A read in the same cycle as a write returns the pre-write value. When not hit, memReadData <= 0 (not Z) so the bus can OR slaves.
- Synchroniser: sync1 <= gpioIn; sync2 <= sync1; prev <= sync2. IN reads sync2. A pin change sampled at edge k is visible in IN at edge k+1 and readable on memReadData at k+2.
- Edge detection: rise = sync2 & ~prev & RISE_EN; fall = ~sync2 & prev & FALL_EN. STATUS |= rise | fall.
- Warm-up: a 2-bit counter counts 0..3 after reset and saturates. Edge capture is suppressed while count < 3, so pins held high through reset produce no event.
- Simultaneous STATUS W1C and new edge on the same bit in the same cycle: the set wins and the bit stays 1.
- Disabling RISE_EN/FALL_EN does not clear already-latched STATUS bits.
- irq = |STATUS, combinational from registered STATUS with no extra latency. It falls the cycle after the last bit is cleared.
- Reset values (async assert, applied immediately):
  - OUT = OUT_RESET; DIR, RISE_EN, FALL_EN, STATUS = 0
  - sync1, sync2, prev = 0; warm-up count = 0
  - memReadData = 0, irq = 0, gpioOe = 0 (all pins inputs)
- Reset deasserted mid-transaction: any write in flight is lost; the bus master must retry.

Decomposition:
- Shared package gpio_pkg:
  - register offset constants (GPIO_OUT, GPIO_DIR, GPIO_IN, GPIO_SET, GPIO_CLR, GPIO_TGL, GPIO_RISE_EN, GPIO_FALL_EN, GPIO_STATUS)
  - GPIO_MAX_PINS = 32
  - a function expanding byteMask to a 32-bit bit mask
- One sub-module, gpio_sync_edge: per-bank synchroniser, prev register, warm-up counter, and rise/fall vector outputs. It is parametrised by NUM_PINS and is reusable for future timer-capture inputs.

Test Plan:
1. Reset with gpioIn = 8'hFF held → gpioOe = 0, gpioOut = 0, irq = 0. No STATUS bits set after warm-up; read 0x08 returns 32'h0000_00FF.
2. Write OUT = 32'hA5 with byteMask 4'b0001, then SET 32'h0F, then CLR 32'h81, then TGL 32'hFF → OUT/gpioOut sequence A5, AF, 2E, D1. Read 0x00 returns 32'h0000_00D1 one cycle after the address.
3. Write OUT = 32'hFFFF_FFFF with byteMask 4'b0010 and NUM_PINS = 8 → OUT unchanged; read of 0x04 with DIR = 32'hFFFF_FFFF written returns 32'h0000_00FF.
4. RISE_EN = 32'h01; raise gpioIn[0] at edge k → STATUS[0] = 1 and irq = 1 at edge k+2. W1C 32'h01 → irq low next cycle. A falling edge with FALL_EN = 0 leaves STATUS = 0.
5. Raise gpioIn[1] (RISE_EN[1] = 1) timed so the edge capture coincides with a W1C of bit 1 → STATUS[1] remains 1 and irq stays high.
6. Read memAddress = BASE_MEMORY − 4 and BASE_MEMORY + 0x40 → memReadData = 0. Writes there leave all registers unchanged. Asserting rst mid-sequence → all registers return to reset values immediately.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO bank: register offsets,
// pin-count limit and the byte-enable expansion helper.
package gpio_pkg;

    localparam int GPIO_MAX_PINS = 32;

    // Byte offsets within the 64-byte register window
    localparam logic [5:0] GPIO_OUT     = 6'h00;
    localparam logic [5:0] GPIO_DIR     = 6'h04;
    localparam logic [5:0] GPIO_IN      = 6'h08;
    localparam logic [5:0] GPIO_SET     = 6'h0C;
    localparam logic [5:0] GPIO_CLR     = 6'h10;
    localparam logic [5:0] GPIO_TGL     = 6'h14;
    localparam logic [5:0] GPIO_RISE_EN = 6'h18;
    localparam logic [5:0] GPIO_FALL_EN = 6'h1C;
    localparam logic [5:0] GPIO_STATUS  = 6'h20;

    // Expand a 4-bit byte enable into a 32-bit per-bit mask
    function automatic logic [31:0] byte_mask_expand(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop input synchroniser with a previous-value register and a
// saturating warm-up counter; emits per-pin rising/falling edge pulses
// once the chain holds real pin history.
module gpio_sync_edge
    import gpio_pkg::*;
#(
    parameter int NUM_PINS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PINS-1:0] pins_in,
    output logic [NUM_PINS-1:0] pins_sync,
    output logic [NUM_PINS-1:0] rise,
    output logic [NUM_PINS-1:0] fall
);

    logic [NUM_PINS-1:0] sync1_p0;
    logic [NUM_PINS-1:0] sync2_p1;
    logic [NUM_PINS-1:0] prev_p2;
    logic [1:0]          warm_cnt;
    logic                armed;

    // Stage p0 -> p1 -> p2: metastability filter, then one cycle of history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_p0 <= '0;
            sync2_p1 <= '0;
            prev_p2  <= '0;
        end else begin
            sync1_p0 <= pins_in;
            sync2_p1 <= sync1_p0;
            prev_p2  <= sync2_p1;
        end
    end

    // Warm-up: count 0..3 after reset so pins held high through reset
    // are not mistaken for a rising edge while the chain fills
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_cnt <= 2'd0;
        end else if (warm_cnt != 2'd3) begin
            warm_cnt <= warm_cnt + 2'd1;
        end
    end

    assign armed     = (warm_cnt == 2'd3);
    assign pins_sync = sync2_p1;
    assign rise      = armed ? (sync2_p1 & ~prev_p2) : '0;
    assign fall      = armed ? (~sync2_p1 & prev_p2) : '0;

endmodule

// File: rtl/gpio_bank_mmio.sv
// Memory-mapped GPIO bank: direction control, atomic set/clear/toggle of
// outputs, synchronised inputs and edge-triggered interrupt capture with
// write-1-to-clear status. Read data is zero when not selected so it can
// be OR-muxed with other bus slaves.
module gpio_bank_mmio
    import gpio_pkg::*;
#(
    parameter int          NUM_PINS    = 8,
    parameter logic [31:0] BASE_MEMORY = 32'hFFFF_FF00,
    parameter logic [31:0] OUT_RESET   = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         memAddress,
    input  logic [31:0]         memWriteData,
    input  logic                memWrite,
    input  logic [3:0]          byteMask,
    output logic [31:0]         memReadData,
    input  logic [NUM_PINS-1:0] gpioIn,
    output logic [NUM_PINS-1:0] gpioOut,
    output logic [NUM_PINS-1:0] gpioOe,
    output logic                irq
);

    logic                hit;
    logic                wr;
    logic [5:0]          reg_off;
    logic [31:0]         bmask;
    logic [31:0]         wbits;
    logic [NUM_PINS-1:0] wen;
    logic [NUM_PINS-1:0] wdat;
    logic                unused_bits;

    logic [NUM_PINS-1:0] out_r;
    logic [NUM_PINS-1:0] dir_r;
    logic [NUM_PINS-1:0] rise_en_r;
    logic [NUM_PINS-1:0] fall_en_r;
    logic [NUM_PINS-1:0] status_r;
    logic [NUM_PINS-1:0] pins_sync;
    logic [NUM_PINS-1:0] rise;
    logic [NUM_PINS-1:0] fall;
    logic [NUM_PINS-1:0] w1c;
    logic [31:0]         rd_nxt;

    // The window is 64-byte aligned, so only the upper address bits select it
    assign hit     = (memAddress[31:6] == BASE_MEMORY[31:6]);
    assign wr      = hit && memWrite;
    assign reg_off = {memAddress[5:2], 2'b00};

    // Disabled byte lanes contribute zero data; bits above NUM_PINS are dropped
    assign bmask = byte_mask_expand(byteMask);
    assign wbits = memWriteData & bmask;
    assign wen   = bmask[NUM_PINS-1:0];
    assign wdat  = wbits[NUM_PINS-1:0];

    // Address byte lane and write-data bits above NUM_PINS carry no state
    assign unused_bits = ^{memAddress[1:0], wbits, bmask};

    gpio_sync_edge #(
        .NUM_PINS (NUM_PINS)
    ) u_sync_edge (
        .clk       (clk),
        .rst       (rst),
        .pins_in   (gpioIn),
        .pins_sync (pins_sync),
        .rise      (rise),
        .fall      (fall)
    );

    // OUT register: direct byte-masked write plus atomic set/clear/toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r <= OUT_RESET[NUM_PINS-1:0];
        end else if (wr) begin
            case (reg_off)
                GPIO_OUT: out_r <= (out_r & ~wen) | wdat;
                GPIO_SET: out_r <= out_r | wdat;
                GPIO_CLR: out_r <= out_r & ~wdat;
                GPIO_TGL: out_r <= out_r ^ wdat;
                default:  out_r <= out_r;
            endcase
        end
    end

    // Direction and edge-enable registers, byte-masked read/write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_r     <= '0;
            rise_en_r <= '0;
            fall_en_r <= '0;
        end else if (wr) begin
            case (reg_off)
                GPIO_DIR:     dir_r     <= (dir_r & ~wen) | wdat;
                GPIO_RISE_EN: rise_en_r <= (rise_en_r & ~wen) | wdat;
                GPIO_FALL_EN: fall_en_r <= (fall_en_r & ~wen) | wdat;
                default: ;
            endcase
        end
    end

    assign w1c = (wr && (reg_off == GPIO_STATUS)) ? wdat : '0;

    // Sticky edge status: clear first, then OR in new edges so a capture
    // in the same cycle as its write-1-to-clear keeps the bit set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_r <= '0;
        end else begin
            status_r <= (status_r & ~w1c) | (rise & rise_en_r) | (fall & fall_en_r);
        end
    end

    // Read mux: current (pre-write) register contents, zero when unselected
    always_comb begin
        rd_nxt = '0;
        if (hit) begin
            case (reg_off)
                GPIO_OUT:     rd_nxt = 32'(out_r);
                GPIO_DIR:     rd_nxt = 32'(dir_r);
                GPIO_IN:      rd_nxt = 32'(pins_sync);
                GPIO_RISE_EN: rd_nxt = 32'(rise_en_r);
                GPIO_FALL_EN: rd_nxt = 32'(fall_en_r);
                GPIO_STATUS:  rd_nxt = 32'(status_r);
                default:      rd_nxt = '0;
            endcase
        end
    end

    // Registered read data, one cycle behind the address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memReadData <= '0;
        end else begin
            memReadData <= rd_nxt;
        end
    end

    assign gpioOut = out_r;
    assign gpioOe  = dir_r;
    assign irq     = |status_r;

endmodule

// File: tb/tb_gpio_bank_mmio.sv
// Directed bench for gpio_bank_mmio: a vector table for register access
// plus hand-timed sequences for warm-up, edge capture, W1C race and reset.
module tb_gpio_bank_mmio;

    localparam logic [31:0] B = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWrite;
    logic [3:0]  byteMask;
    logic [31:0] memReadData;
    logic [7:0]  gpioIn;
    logic [7:0]  gpioOut;
    logic [7:0]  gpioOe;
    logic        irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
        logic [7:0]  exp_oe;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

    gpio_bank_mmio #(
        .NUM_PINS    (8),
        .BASE_MEMORY (32'hFFFF_FF00),
        .OUT_RESET   (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memWrite     (memWrite),
        .byteMask     (byteMask),
        .memReadData  (memReadData),
        .gpioIn       (gpioIn),
        .gpioOut      (gpioOut),
        .gpioOe       (gpioOe),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Present one bus cycle, return 1 time unit after the capturing edge
    task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b);
        memWrite     = wr;
        memAddress   = a;
        memWriteData = d;
        byteMask     = b;
        @(posedge clk);
        #1;
        memWrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic [31:0] rd, input logic [7:0] o, input logic [7:0] oe);
        vecs[i] = '{wr, a, d, b, rd, o, oe};
    endtask

    initial begin
        //  idx wr  address          data           be     read-back      out    oe
        setv( 0, 1, B + 32'h00,     32'h0000_00A5, 4'h1, 32'h0000_0000, 8'hA5, 8'h00);
        setv( 1, 1, B + 32'h0C,     32'h0000_000F, 4'hF, 32'h0000_0000, 8'hAF, 8'h00);
        setv( 2, 1, B + 32'h10,     32'h0000_0081, 4'hF, 32'h0000_0000, 8'h2E, 8'h00);
        setv( 3, 1, B + 32'h14,     32'h0000_00FF, 4'hF, 32'h0000_0000, 8'hD1, 8'h00);
        setv( 4, 0, B + 32'h00,     32'h0,         4'h0, 32'h0000_00D1, 8'hD1, 8'h00);
        setv( 5, 1, B + 32'h00,     32'hFFFF_FFFF, 4'h2, 32'h0000_00D1, 8'hD1, 8'h00);
        setv( 6, 1, B + 32'h04,     32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 8'hD1, 8'hFF);
        setv( 7, 0, B + 32'h04,     32'h0,         4'h0, 32'h0000_00FF, 8'hD1, 8'hFF);
        setv( 8, 0, B + 32'h08,     32'h0,         4'h0, 32'h0000_00FF, 8'hD1, 8'hFF);
        setv( 9, 0, B + 32'h0C,     32'h0,         4'h0, 32'h0000_0000, 8'hD1, 8'hFF);
        setv(10, 0, B + 32'h20,     32'h0,         4'h0, 32'h0000_0000, 8'hD1, 8'hFF);
        setv(11, 1, B + 32'h0C,     32'h0000_FF00, 4'hF, 32'h0000_0000, 8'hD1, 8'hFF);
        setv(12, 1, B + 32'h10,     32'h0000_00FF, 4'hE, 32'h0000_0000, 8'hD1, 8'hFF);
        setv(13, 1, B + 32'h14,     32'h0000_000F, 4'h1, 32'h0000_0000, 8'hDE, 8'hFF);
        setv(14, 0, B + 32'h24,     32'h0,         4'h0, 32'h0000_0000, 8'hDE, 8'hFF);
        setv(15, 0, B + 32'h3C,     32'h0,         4'h0, 32'h0000_0000, 8'hDE, 8'hFF);
        setv(16, 1, B + 32'h24,     32'h0000_00FF, 4'hF, 32'h0000_0000, 8'hDE, 8'hFF);
        setv(17, 1, B + 32'h40,     32'h0000_00FF, 4'hF, 32'h0000_0000, 8'hDE, 8'hFF);
        setv(18, 0, B + 32'h40,     32'h0,         4'h0, 32'h0000_0000, 8'hDE, 8'hFF);
        setv(19, 1, 32'hFFFF_FE00,  32'h0000_0000, 4'hF, 32'h0000_0000, 8'hDE, 8'hFF);
        setv(20, 0, 32'hFFFF_FEFC,  32'h0,         4'h0, 32'h0000_0000, 8'hDE, 8'hFF);
        setv(21, 1, B + 32'h00,     32'h0000_0033, 4'h1, 32'h0000_00DE, 8'h33, 8'hFF);
        setv(22, 1, B + 32'h04,     32'h0000_000F, 4'h1, 32'h0000_00FF, 8'h33, 8'h0F);
        setv(23, 1, B + 32'h18,     32'h0000_0103, 4'h1, 32'h0000_0000, 8'h33, 8'h0F);
        setv(24, 0, B + 32'h18,     32'h0,         4'h0, 32'h0000_0003, 8'h33, 8'h0F);
        setv(25, 1, B + 32'h1C,     32'h0000_00FF, 4'h0, 32'h0000_0000, 8'h33, 8'h0F);
        setv(26, 0, B + 32'h1C,     32'h0,         4'h0, 32'h0000_0000, 8'h33, 8'h0F);
        setv(27, 1, B + 32'h18,     32'h0000_0000, 4'hF, 32'h0000_0003, 8'h33, 8'h0F);
        setv(28, 0, B + 32'h02,     32'h0,         4'h0, 32'h0000_0033, 8'h33, 8'h0F);
        setv(29, 1, B + 32'h13,     32'h0000_00F0, 4'hF, 32'h0000_0000, 8'h03, 8'h0F);

        // Reset with all pins held high
        rst          = 1'b1;
        gpioIn       = 8'hFF;
        memWrite     = 1'b0;
        memAddress   = 32'h0;
        memWriteData = 32'h0;
        byteMask     = 4'h0;
        idle(3);
        chk("reset gpioOe",  {24'h0, gpioOe},  32'h0);
        chk("reset gpioOut", {24'h0, gpioOut}, 32'h0);
        chk("reset irq",     {31'h0, irq},     32'h0);
        chk("reset rdata",   memReadData,      32'h0);
        rst = 1'b0;

        // Enable rising capture on the first edge out of reset: warm-up must
        // hide the apparent 0->1 transition of the held-high pins
        bus(1'b1, B + 32'h18, 32'h0000_00FF, 4'hF);
        idle(4);
        bus(1'b0, B + 32'h20, 32'h0, 4'h0);
        chk("warmup status", memReadData, 32'h0);
        chk("warmup irq", {31'h0, irq}, 32'h0);
        bus(1'b1, B + 32'h18, 32'h0, 4'hF);
        bus(1'b0, B + 32'h08, 32'h0, 4'h0);
        chk("warmup IN", memReadData, 32'h0000_00FF);

        // Table-driven register accesses
        for (int i = 0; i < NV; i++) begin
            bus(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be);
            chk($sformatf("vec%0d rdata", i), memReadData, vecs[i].exp_rd);
            chk($sformatf("vec%0d gpioOut", i), {24'h0, gpioOut}, {24'h0, vecs[i].exp_out});
            chk($sformatf("vec%0d gpioOe", i), {24'h0, gpioOe}, {24'h0, vecs[i].exp_oe});
        end

        // Falling edges with FALL_EN clear must not latch; then a rising edge
        // on pin 0 sampled at edge k reaches STATUS/irq at edge k+2
        bus(1'b1, B + 32'h18, 32'h0000_0001, 4'hF);
        gpioIn = 8'h00;
        idle(4);
        bus(1'b0, B + 32'h20, 32'h0, 4'h0);
        chk("fall disabled status", memReadData, 32'h0);
        chk("fall disabled irq", {31'h0, irq}, 32'h0);
        gpioIn = 8'h01;
        @(posedge clk); #1;
        chk("rise irq k", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        chk("rise irq k+1", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        chk("rise irq k+2", {31'h0, irq}, 32'h1);
        bus(1'b0, B + 32'h20, 32'h0, 4'h0);
        chk("rise status", memReadData, 32'h0000_0001);
        bus(1'b1, B + 32'h20, 32'h0000_0001, 4'hF);
        chk("w1c irq", {31'h0, irq}, 32'h0);
        bus(1'b0, B + 32'h20, 32'h0, 4'h0);
        chk("w1c status", memReadData, 32'h0);

        // W1C of bit 1 lands on the same edge that captures its rising edge
        bus(1'b1, B + 32'h18, 32'h0000_0003, 4'hF);
        gpioIn = 8'h03;
        @(posedge clk);
        @(posedge clk); #1;
        bus(1'b1, B + 32'h20, 32'h0000_0002, 4'hF);
        chk("race irq", {31'h0, irq}, 32'h1);
        bus(1'b0, B + 32'h20, 32'h0, 4'h0);
        chk("race status", memReadData, 32'h0000_0002);
        bus(1'b1, B + 32'h18, 32'h0, 4'hF);
        bus(1'b0, B + 32'h20, 32'h0, 4'h0);
        chk("disable keeps status", memReadData, 32'h0000_0002);
        chk("disable keeps irq", {31'h0, irq}, 32'h1);

        // Asynchronous reset mid-sequence
        bus(1'b1, B + 32'h00, 32'h0000_0055, 4'h1);
        bus(1'b1, B + 32'h04, 32'h0000_00FF, 4'h1);
        bus(1'b0, B + 32'h00, 32'h0, 4'h0);
        chk("pre-reset rdata", memReadData, 32'h0000_0055);
        rst = 1'b1;
        #2;
        chk("async gpioOut", {24'h0, gpioOut}, 32'h0);
        chk("async gpioOe",  {24'h0, gpioOe},  32'h0);
        chk("async irq",     {31'h0, irq},     32'h0);
        chk("async rdata",   memReadData,      32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);
        bus(1'b0, B + 32'h04, 32'h0, 4'h0);
        chk("post-reset DIR", memReadData, 32'h0);
        bus(1'b0, B + 32'h20, 32'h0, 4'h0);
        chk("post-reset STATUS", memReadData, 32'h0);
        bus(1'b0, B + 32'h08, 32'h0, 4'h0);
        chk("post-reset IN", memReadData, 32'h0000_0003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
